// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Optional PWM dimming is enabled in the top level with DISPLAY_SCAN_PWM_EN.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } scan_state_t;

    localparam int SEG_NIBBLE_W = 4;

    // Digit index width; a 1-bit index is kept even for degenerate counts.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_rr_next_digit.sv
// Combinational round-robin finder: first enabled digit strictly after cur_idx,
// wrapping around; wrap flags a result at or below cur_idx (frame wrap).
module rr_next_digit
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SEL_W      = sel_width(NUM_DIGITS)
) (
    input  logic [NUM_DIGITS-1:0] en_mask,
    input  logic [SEL_W-1:0]      cur_idx,
    output logic [SEL_W-1:0]      next_idx,
    output logic                  wrap
);

    always_comb begin
        int best_off;
        int off;
        next_idx = cur_idx;
        wrap     = 1'b1;
        best_off = NUM_DIGITS + 1;
        off      = 0;
        // Distance from cur_idx going forward; cur_idx itself sits at distance N.
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (d > int'(cur_idx)) off = d - int'(cur_idx);
            else                   off = d - int'(cur_idx) + NUM_DIGITS;
            if (en_mask[d] && (off < best_off)) begin
                best_off = off;
                next_idx = SEL_W'(d);
                wrap     = (d <= int'(cur_idx));
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blanking, digit skipping and
// tear-free frame-boundary updates. Define DISPLAY_SCAN_PWM_EN for PWM dimming.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 333333,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 19
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_DIGITS-1:0]             digit_en,
    input  logic                              upd_valid,
    input  logic [4*NUM_DIGITS-1:0]           upd_data,
`ifdef DISPLAY_SCAN_PWM_EN
    input  logic [3:0]                        brightness,
`endif
    output logic                              upd_ready,
    output logic [NUM_DIGITS-1:0]             an_n,
    output logic [$clog2(NUM_DIGITS)-1:0]     sel,
    output logic [3:0]                        hex_out,
    output logic                              frame_tick,
    output logic [1:0]                        dbg_state
);

    localparam int SEL_W = sel_width(NUM_DIGITS);
    localparam bit HAS_BLANK = (BLANK_CYCLES != 0);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

    scan_state_t                 r_state;
    logic [CNT_W-1:0]            r_timer;
    logic [SEL_W-1:0]            r_sel;
    logic [NUM_DIGITS-1:0]       r_an_n;
    logic                        r_ft;
    logic [3:0]                  r_hex;
    logic [4*NUM_DIGITS-1:0]     r_active;
    logic [4*NUM_DIGITS-1:0]     r_pend;
    logic                        r_pend_full;

    logic                        w_any_en;
    logic                        w_sel_en;
    logic                        w_dwell_done;
    logic                        w_blank_done;
    logic                        w_dwell_end;
    logic [SEL_W-1:0]            w_rr_cur;
    logic [SEL_W-1:0]            w_next;
    logic                        w_wrap;
    logic [NUM_DIGITS-1:0]       w_lit_cur;
    logic [NUM_DIGITS-1:0]       w_lit_next;
    logic                        w_boundary;
    logic                        w_xfer;
    logic                        w_apply;

    assign w_any_en     = |digit_en;
    assign w_sel_en     = digit_en[r_sel];
    assign w_dwell_done = (r_timer == DWELL_LAST);
    assign w_blank_done = (r_timer == BLANK_LAST);
    assign w_dwell_end  = w_dwell_done || !w_sel_en;
    // From IDLE, searching after the last index yields the lowest enabled digit.
    assign w_rr_cur     = (r_state == IDLE) ? SEL_W'(NUM_DIGITS - 1) : r_sel;
    assign w_lit_cur    = ~(NUM_DIGITS'(1) << r_sel);
    assign w_lit_next   = ~(NUM_DIGITS'(1) << w_next);

    rr_next_digit #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEL_W      (SEL_W)
    ) u_rr (
        .en_mask  (digit_en),
        .cur_idx  (w_rr_cur),
        .next_idx (w_next),
        .wrap     (w_wrap)
    );

    // Scan sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_sel   <= '0;
            r_an_n  <= '1;
            r_ft    <= 1'b0;
        end else begin
            r_ft <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_an_n <= '1;
                    if (w_any_en) begin
                        r_sel   <= w_next;
                        r_timer <= '0;
                        r_ft    <= 1'b1;
                        if (HAS_BLANK) begin
                            r_state <= BLANK;
                        end else begin
                            r_state <= DWELL;
                            r_an_n  <= w_lit_next;
                        end
                    end
                end
                BLANK: begin
                    if (!w_any_en) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_an_n  <= '1;
                    end else if (w_blank_done) begin
                        r_state <= DWELL;
                        r_timer <= '0;
                        r_an_n  <= w_lit_cur;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DWELL: begin
                    if (!w_any_en) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_an_n  <= '1;
                    end else if (w_dwell_end) begin
                        r_sel   <= w_next;
                        r_timer <= '0;
                        r_ft    <= w_wrap;
                        if (HAS_BLANK) begin
                            r_state <= BLANK;
                            r_an_n  <= '1;
                        end else begin
                            r_state <= DWELL;
                            r_an_n  <= w_lit_next;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                    r_an_n  <= '1;
                end
            endcase
        end
    end

    // Update handshake: a word transfers on any cycle where upd_valid and
    // upd_ready are both high; upd_valid/upd_data must hold until then and
    // upd_ready stays low while a captured word waits for a frame boundary.
    assign w_boundary = ((r_state == IDLE) && w_any_en) ||
                        ((r_state == DWELL) && w_any_en && w_dwell_end && w_wrap);
    assign w_xfer     = upd_valid && !r_pend_full;
    assign w_apply    = r_pend_full && (w_boundary || (r_state == IDLE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active    <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
            r_hex       <= '0;
        end else begin
            r_hex <= r_active[{r_sel, 2'b00} +: SEG_NIBBLE_W];
            if (w_xfer) begin
                r_pend      <= upd_data;
                r_pend_full <= 1'b1;
            end else if (w_apply) begin
                r_active    <= r_pend;
                r_pend_full <= 1'b0;
            end
        end
    end

`ifdef DISPLAY_SCAN_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic       r_pwm_on;

    // r_pwm_on is computed for the count value r_pwm_cnt takes this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_pwm_on  <= 1'b1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            r_pwm_on  <= ((r_pwm_cnt + 4'd1) <= brightness);
        end
    end

    assign an_n = r_an_n | {NUM_DIGITS{~r_pwm_on}};
`else
    assign an_n = r_an_n;
`endif

    assign upd_ready  = ~r_pend_full;
    assign sel        = r_sel;
    assign hex_out    = r_hex;
    assign frame_tick = r_ft;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (2 digits, dwell 8, blank 2).
// Builds with or without DISPLAY_SCAN_PWM_EN (brightness held at full).
module tb_display_scan_ctrl;
  import disp_pkg::*;

  localparam int ND = 2;
  localparam int DW = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  digit_en;
  logic        upd_valid;
  logic [7:0]  upd_data;
  logic        upd_ready;
  logic [1:0]  an_n;
  logic        sel;
  logic [3:0]  hex_out;
  logic        frame_tick;
  logic [1:0]  dbg_state;
`ifdef DISPLAY_SCAN_PWM_EN
  logic [3:0]  brightness = 4'hF;
`endif

  // clock / reset
  always #5 clk = ~clk;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_en   (digit_en),
    .upd_valid  (upd_valid),
    .upd_data   (upd_data),
`ifdef DISPLAY_SCAN_PWM_EN
    .brightness (brightness),
`endif
    .upd_ready  (upd_ready),
    .an_n       (an_n),
    .sel        (sel),
    .hex_out    (hex_out),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // scoreboard: expected {frame_tick, sel, an_n} per cycle
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_blank(input logic s, input logic ft);
    for (int i = 0; i < BL; i++) exp_q.push_back({(i == 0) ? ft : 1'b0, s, 2'b11});
  endtask

  task automatic push_dwell(input logic s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, s, s ? 2'b01 : 2'b10});
  endtask

  task automatic push_visit(input logic s, input logic ft);
    push_blank(s, ft);
    push_dwell(s, DW);
  endtask

  task automatic consume(input int n);
    logic [3:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL scan: got %0h with no expected entry at %0t", {frame_tick, sel, an_n}, $time);
      end else begin
        exp = exp_q.pop_front();
        check_eq("scan", {28'd0, frame_tick, sel, an_n}, {28'd0, exp});
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    digit_en  = 2'b00;
    upd_valid = 1'b0;
    upd_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_an_n", an_n, 2'b11);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_hex", hex_out, 0);
    check_eq("rst_tick", frame_tick, 0);
    check_eq("rst_ready", upd_ready, 1);
    check_eq("rst_state", dbg_state, 32'(IDLE));
    reset = 1'b0;

    // both digits: two full frames
    digit_en = 2'b11;
    push_visit(1'b0, 1'b1); push_visit(1'b1, 1'b0);
    push_visit(1'b0, 1'b1); push_visit(1'b1, 1'b0);
    consume(40);

    // update offered mid-frame, applied at the next frame boundary
    push_visit(1'b0, 1'b1); push_visit(1'b1, 1'b0);
    consume(5);
    upd_valid = 1'b1;
    upd_data  = 8'h5A;
    consume(1);
    check_eq("upd_ready_low", upd_ready, 0);
    upd_valid = 1'b0;
    consume(13);
    check_eq("hex_before_tick", hex_out, 4'h0);
    consume(1);
    push_visit(1'b0, 1'b1); push_visit(1'b1, 1'b0);
    consume(1);
    check_eq("upd_ready_high", upd_ready, 1);
    consume(1);
    check_eq("hex_digit0", hex_out, 4'hA);
    consume(10);
    check_eq("hex_digit1", hex_out, 4'h5);
    consume(8);

    // only digit 1 enabled: every visit is a wrap
    digit_en = 2'b10;
    push_visit(1'b1, 1'b1); push_visit(1'b1, 1'b1); push_visit(1'b1, 1'b1);
    consume(30);

    // digit 0 disabled mid-dwell
    digit_en = 2'b11;
    push_blank(1'b0, 1'b1);
    push_dwell(1'b0, 3);
    consume(5);
    digit_en = 2'b10;
    push_visit(1'b1, 1'b0);
    consume(10);

    // reset during dwell with a pending word
    push_blank(1'b1, 1'b1);
    push_dwell(1'b1, 3);
    consume(2);
    upd_valid = 1'b1;
    upd_data  = 8'hC3;
    consume(1);
    check_eq("pend_ready_low", upd_ready, 0);
    upd_valid = 1'b0;
    consume(2);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_an_n", an_n, 2'b11);
    check_eq("mid_rst_sel", sel, 0);
    check_eq("mid_rst_ready", upd_ready, 1);
    check_eq("mid_rst_tick", frame_tick, 0);
    reset = 1'b0;
    push_visit(1'b1, 1'b1);
    consume(2);
    check_eq("pend_discarded", hex_out, 4'h0);
    consume(8);

    // all digits off, then an update applied while idle
    digit_en = 2'b00;
    @(negedge clk);
    check_eq("idle_an_n", an_n, 2'b11);
    check_eq("idle_state", dbg_state, 32'(IDLE));
    check_eq("idle_tick", frame_tick, 0);
    upd_valid = 1'b1;
    upd_data  = 8'h96;
    @(negedge clk);
    check_eq("idle_ready_low", upd_ready, 0);
    upd_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_ready_high", upd_ready, 1);
    check_eq("idle_apply_tick", frame_tick, 0);
    @(negedge clk);
    check_eq("idle_hex", hex_out, 4'h9);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
